// File: rtl/inst_mem_pkg.sv
// Shared constants and helpers for the instruction byte memory.
// Contains no logic, so there is no latency and no backpressure.
package inst_mem_pkg;

  localparam int DEFAULT_DEPTH = 256;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // b0 sits at the lowest address and becomes the most significant byte.
  function automatic logic [31:0] be_word(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/inst_ram_256x8_if.sv
// Read and write bus of the instruction memory; adds Misaligned when INST_MEM_ALIGN_CHECK_EN is defined.
// Plain wires: no latency, no backpressure.
interface inst_ram_256x8_if;

  logic        Enable;
  logic [31:0] Address;
  logic [31:0] DataOut;
  logic        WriteEn;
  logic [1:0]  WriteSize;
  logic [31:0] WriteAddr;
  logic [31:0] WriteData;
  logic        WriteErr;
`ifdef INST_MEM_ALIGN_CHECK_EN
  logic        Misaligned;
`endif

  modport master (
    output Enable, Address, WriteEn, WriteSize, WriteAddr, WriteData,
`ifdef INST_MEM_ALIGN_CHECK_EN
    input  Misaligned,
`endif
    input  DataOut, WriteErr
  );

  modport slave (
    input  Enable, Address, WriteEn, WriteSize, WriteAddr, WriteData,
`ifdef INST_MEM_ALIGN_CHECK_EN
    output Misaligned,
`endif
    output DataOut, WriteErr
  );

endinterface

// File: rtl/inst_mem_wr_decode.sv
// Maps a store (size, byte address, data) to four big-endian byte lanes with wrapped indices.
// Combinational: no latency, no backpressure.
module inst_mem_wr_decode
  import inst_mem_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic [1:0]             size_i,
  input  logic [AW-1:0]          addr_i,
  input  logic [31:0]            data_i,
  output logic [3:0]             lane_en_o,
  output logic [3:0][AW-1:0]     lane_idx_o,
  output logic [3:0][7:0]        lane_dat_o
);

  always_comb begin
    lane_en_o  = 4'b0000;
    lane_dat_o = '0;
    // AW-bit addition wraps the index modulo the memory depth for free.
    for (int i = 0; i < 4; i++) begin
      lane_idx_o[i] = addr_i + AW'(i);
    end
    case (size_i)
      SZ_BYTE: begin
        lane_en_o     = 4'b0001;
        lane_dat_o[0] = data_i[7:0];
      end
      SZ_HALF: begin
        lane_en_o     = 4'b0011;
        lane_dat_o[0] = data_i[15:8];
        lane_dat_o[1] = data_i[7:0];
      end
      SZ_WORD: begin
        lane_en_o     = 4'b1111;
        lane_dat_o[0] = data_i[31:24];
        lane_dat_o[1] = data_i[23:16];
        lane_dat_o[2] = data_i[15:8];
        lane_dat_o[3] = data_i[7:0];
      end
      default: lane_en_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/inst_ram_256x8.sv
// Byte-addressed instruction RAM: combinational big-endian 32-bit read, synchronous 1/2/4-byte write,
// no backpressure. INST_MEM_ALIGN_CHECK_EN adds the advisory Misaligned output.
module inst_ram_256x8
  import inst_mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  inst_ram_256x8_if.slave  bus
);

  // Deliberately unreset so a preloaded program survives reset.
  logic [7:0] Mem [0:DEPTH-1];

  logic [AW-1:0]      rd_idx;
  logic [31:0]        rd_word;
  logic [3:0]         lane_en;
  logic [3:0][AW-1:0] lane_idx;
  logic [3:0][7:0]    lane_dat;
  logic               write_err_d;
  logic               write_err_q;
  logic               unused_addr_hi;

  assign rd_idx  = bus.Address[AW-1:0];
  assign rd_word = be_word(Mem[rd_idx], Mem[rd_idx + AW'(1)],
                           Mem[rd_idx + AW'(2)], Mem[rd_idx + AW'(3)]);

  assign bus.DataOut = (bus.Enable && !reset) ? rd_word : 32'h0000_0000;

  inst_mem_wr_decode #(
    .AW (AW)
  ) u_wr_decode (
    .size_i     (bus.WriteSize),
    .addr_i     (bus.WriteAddr[AW-1:0]),
    .data_i     (bus.WriteData),
    .lane_en_o  (lane_en),
    .lane_idx_o (lane_idx),
    .lane_dat_o (lane_dat)
  );

  always_ff @(posedge clk) begin
    if (!reset && bus.WriteEn) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) begin
          Mem[lane_idx[i]] <= lane_dat[i];
        end
      end
    end
  end

  assign write_err_d = write_err_q || (bus.WriteEn && (bus.WriteSize == SZ_RSVD));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_err_q <= 1'b0;
    end else begin
      write_err_q <= write_err_d;
    end
  end

  assign bus.WriteErr = write_err_q;

`ifdef INST_MEM_ALIGN_CHECK_EN
  assign bus.Misaligned = bus.Enable && !reset && (bus.Address[1:0] != 2'b00);
`endif

  // Upper address bits are ignored by design.
  assign unused_addr_hi = ^{bus.Address[31:AW], bus.WriteAddr[31:AW]};

endmodule

// File: tb/tb_inst_ram_256x8.sv
// Randomised self-checking bench for inst_ram_256x8 against an array-based reference model.
module tb_inst_ram_256x8;

  logic clk;
  logic reset;

  inst_ram_256x8_if bus ();

  inst_ram_256x8 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass;
  int n_total;

  logic [7:0] ref_mem [256];
  logic       err_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr, input logic en);
    int unsigned a;
    a = addr % 256;
    if (!en) return 32'h0;
    return {ref_mem[a], ref_mem[(a + 1) % 256], ref_mem[(a + 2) % 256], ref_mem[(a + 3) % 256]};
  endfunction

  function automatic void model_write(input logic [1:0] sz, input logic [31:0] addr,
                                      input logic [31:0] data);
    int unsigned a;
    a = addr % 256;
    case (sz)
      2'b00: ref_mem[a] = data[7:0];
      2'b01: begin
        ref_mem[a]             = data[15:8];
        ref_mem[(a + 1) % 256] = data[7:0];
      end
      2'b10: begin
        ref_mem[a]             = data[31:24];
        ref_mem[(a + 1) % 256] = data[23:16];
        ref_mem[(a + 2) % 256] = data[15:8];
        ref_mem[(a + 3) % 256] = data[7:0];
      end
      default: err_exp = 1'b1;
    endcase
  endfunction

  task automatic preload(input int idx, input logic [7:0] val);
    dut.Mem[idx] = val;
    ref_mem[idx] = val;
  endtask

  // Drives one store; checks the old data before the edge and the new data after it.
  task automatic do_write(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] data);
    @(negedge clk);
    bus.WriteEn   = 1'b1;
    bus.WriteSize = sz;
    bus.WriteAddr = addr;
    bus.WriteData = data;
    bus.Enable    = 1'b1;
    bus.Address   = {$urandom_range(0, 255), 16'h0, addr[7:0]};
    #1;
    check_val({tag, "_pre"}, bus.DataOut, model_read(bus.Address, 1'b1));
    @(posedge clk);
    #1;
    bus.WriteEn = 1'b0;
    model_write(sz, addr, data);
    check_val({tag, "_post"}, bus.DataOut, model_read(bus.Address, 1'b1));
    check_val({tag, "_err"}, {31'h0, bus.WriteErr}, {31'h0, err_exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] data;

    n_pass        = 0;
    n_total       = 0;
    err_exp       = 1'b0;
    reset         = 1'b0;
    bus.Enable    = 1'b0;
    bus.Address   = 32'h0;
    bus.WriteEn   = 1'b0;
    bus.WriteSize = 2'b00;
    bus.WriteAddr = 32'h0;
    bus.WriteData = 32'h0;

    #1 reset = 1'b1;
    bus.Enable = 1'b1;
    #1;
    check_val("rst_dataout", bus.DataOut, 32'h0);
    check_val("rst_writeerr", {31'h0, bus.WriteErr}, 32'h0);

    for (int i = 0; i < 256; i++) preload(i, (i < 16) ? 8'(i) : 8'($urandom));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int a = 0; a < 16; a++) begin
      bus.Address = a;
      bus.Enable  = 1'b0;
      #5 bus.Enable = 1'b1;
      #1;
      check_val($sformatf("sweep_%0d", a), bus.DataOut, model_read(a, 1'b1));
      if (a == 0) check_val("rd_addr0", bus.DataOut, 32'h00010203);
      if (a == 1) check_val("rd_addr1", bus.DataOut, 32'h01020304);
      #4;
    end

    bus.Enable  = 1'b0;
    bus.Address = 32'h0;
    #1 check_val("enable_low", bus.DataOut, 32'h0);

    @(negedge clk);
    bus.Enable = 1'b1;
    reset      = 1'b1;
    #1 check_val("rst_en_high", bus.DataOut, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("mem0_survives", {24'h0, dut.Mem[0]}, 32'h0);
    check_val("rd_after_rst", bus.DataOut, 32'h00010203);

    do_write("word_wr", 2'b10, 32'd8, 32'hDEADBEEF);
    bus.Address = 32'd8;
    #1 check_val("word_rd", bus.DataOut, 32'hDEADBEEF);
    do_write("byte_wr", 2'b00, 32'd9, 32'h0000_0055);
    bus.Address = 32'd8;
    #1 check_val("byte_rd", bus.DataOut, 32'hDE55BEEF);

    preload(255, 8'hAA);
    preload(0, 8'h11);
    preload(1, 8'h22);
    preload(2, 8'h33);
    bus.Address = 32'd255;
    #1 check_val("wrap_255", bus.DataOut, 32'hAA112233);
    bus.Address = 32'h0000_01FF;
    #1 check_val("wrap_1ff", bus.DataOut, 32'hAA112233);

    // Reserved size: nothing stored, sticky error set at the edge.
    @(negedge clk);
    bus.WriteEn   = 1'b1;
    bus.WriteSize = 2'b11;
    bus.WriteAddr = 32'd20;
    bus.WriteData = 32'hFFFF_FFFF;
    bus.Address   = 32'd20;
    #1 check_val("rsvd_pre_err", {31'h0, bus.WriteErr}, 32'h0);
    @(posedge clk);
    #1 bus.WriteEn = 1'b0;
    err_exp = 1'b1;
    check_val("rsvd_mem", bus.DataOut, model_read(32'd20, 1'b1));
    check_val("rsvd_err", {31'h0, bus.WriteErr}, 32'h1);
    @(negedge clk);
    #1 check_val("rsvd_err_hold", {31'h0, bus.WriteErr}, 32'h1);
    #1 reset = 1'b1;
    #1 check_val("rsvd_err_clr", {31'h0, bus.WriteErr}, 32'h0);
    #1 reset = 1'b0;
    err_exp = 1'b0;

`ifdef INST_MEM_ALIGN_CHECK_EN
    bus.Enable  = 1'b1;
    bus.Address = 32'd2;
    #1 check_val("misal_2", {31'h0, bus.Misaligned}, 32'h1);
    bus.Address = 32'd4;
    #1 check_val("misal_4", {31'h0, bus.Misaligned}, 32'h0);
    bus.Address = 32'd3;
    bus.Enable  = 1'b0;
    #1 check_val("misal_dis", {31'h0, bus.Misaligned}, 32'h0);
`endif

    for (int n = 0; n < 150; n++) begin
      sz   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = $urandom;
      if ($urandom_range(0, 3) == 0) addr[7:0] = 8'(252 + $urandom_range(0, 3));
      data = $urandom;
      do_write($sformatf("rnd_wr%0d", n), sz, addr, data);
      @(negedge clk);
      bus.Address = $urandom;
      bus.Enable  = 1'($urandom_range(0, 1));
      #1 check_val($sformatf("rnd_rd%0d", n), bus.DataOut, model_read(bus.Address, bus.Enable));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_ram_256x8.md
Name: inst_ram_256x8

Overview:
- Instruction memory for the pipelined RISC CPU: 256 x 8-bit byte array.
- Returns a 32-bit big-endian instruction word from any byte address. Unaligned addresses are allowed.
- Read path is combinational, gated by Enable.
- A synchronous write port loads program images. Testbenches may also preload the array hierarchically through the `Mem` array.

Parameters:
- DEPTH, 256, number of bytes; power of two, address wraps modulo DEPTH.
- AW, 8, log2(DEPTH); index bits taken from Address[AW-1:0].

Ports:
- clk  input  1  rising-edge clock for the write port.
- reset  input  1  asynchronous, active-high reset.
- Enable  input  1  read enable; 1 drives the addressed word, 0 drives zero.
- Address  input  32  byte read address; only bits [AW-1:0] used.
- DataOut  output  32  instruction word.
- WriteEn  input  1  synchronous write strobe.
- WriteSize  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (no write).
- WriteAddr  input  32  byte write address; bits [AW-1:0] used.
- WriteData  input  32  store data, right-justified.
- WriteErr  output  1  sticky flag: a reserved WriteSize was presented while WriteEn = 1.

Behaviour:
- Storage: reg [7:0] Mem[0:DEPTH-1], named exactly `Mem` so benches can write `dut.Mem[i]` directly.
- Read (combinational, zero latency):
  - Let A = Address[AW-1:0].
  - DataOut = {Mem[A], Mem[A+1], Mem[A+2], Mem[A+3]}.
  - Indices wrap modulo DEPTH, so A = 255 gives {Mem[255], Mem[0], Mem[1], Mem[2]}.
- Enable = 0 -> DataOut = 32'h0000_0000.
- reset = 1 -> DataOut = 0, WriteErr = 0, writes suppressed.
- Memory contents are NOT cleared by reset, so a preloaded program survives reset.
- Write (posedge clk, WriteEn = 1, reset = 0), big-endian; let W = WriteAddr[AW-1:0]:
  - Byte: Mem[W] <= WriteData[7:0].
  - Halfword: Mem[W] <= WriteData[15:8], Mem[W+1] <= WriteData[7:0].
  - Word: Mem[W..W+3] <= WriteData[31:24], [23:16], [15:8], [7:0].
  - Write indices wrap modulo DEPTH.
- Write-read collision: a read of a byte being written returns the old byte until the clock edge, and the new byte combinationally after it. No bypass.
- WriteSize = 11 with WriteEn = 1: no memory change; WriteErr <= 1 at the edge. WriteErr holds until reset.
- Address bits above AW-1 are ignored: no fault, no aliasing check.
- Uninitialised bytes read as X in simulation; no implicit zero-fill.

Optional Feature:
- Macro INST_MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output port Misaligned (1 bit, combinational).
  - Misaligned = Enable & ~reset & (Address[1:0] != 2'b00).
  - DataOut is still the unaligned word; the flag is advisory.
- Undefined: the port and its logic are absent; unaligned reads are silently supported.

Decomposition:
- Shared package inst_mem_pkg:
  - localparams SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10.
  - Default DEPTH = 256.
  - Function be_word(b0, b1, b2, b3) that assembles the big-endian word.
- One sub-module is natural: inst_mem_wr_decode. It maps (WriteSize, W, WriteData) to four byte-lane enables, four wrapped indices and four lane bytes.
- The top holds the array, the read mux and WriteErr.

Test Plan:
- Preload Mem[0..15] = 8'h00..8'h0F via hierarchy; Enable = 1, Address = 0 -> DataOut = 32'h00010203. Address = 1 -> 32'h01020304. Sweep 16 addresses, toggling Enable every 5 time units and checking 1 time unit after each rise.
- Enable = 0 at Address = 0 -> DataOut = 0. Assert reset with Enable = 1 -> DataOut = 0; Mem[0] still 8'h00 after reset release.
- Word write 32'hDEADBEEF at WriteAddr = 8 -> Address = 8 reads 32'hDEADBEEF. Byte write 8'h55 at 9 -> Address = 8 reads 32'hDE55BEEF.
- Wrap: Mem[255] = 8'hAA, Mem[0..2] = 8'h11, 8'h22, 8'h33; Address = 255 -> 32'hAA112233. Address = 32'h0000_01FF gives the same word.
- WriteSize = 11 with WriteEn = 1 -> memory unchanged, WriteErr = 1 after the edge and held until async reset clears it mid-cycle.
- INST_MEM_ALIGN_CHECK_EN defined: Address = 2 with Enable = 1 -> Misaligned = 1. Address = 4 -> Misaligned = 0.
